// File: rtl/sysbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sysbus_if : one Sysbus port (request channel + response channel).
//
// Handshake: a request beat transfers on a rising clk edge where reqcyc and
// reqack are both 1. A response beat transfers on a rising clk edge where
// respcyc and respack are both 1. The valid side (reqcyc / respcyc) holds its
// beat stable until it transfers. The ready side (reqack / respack) may rise
// or fall at any time.
//
// Signals
//   req      [DATA_W] request address/data beat       (master -> slave)
//   reqcyc   [1]      request beat valid              (master -> slave)
//   reqtag   [TAG_W]  request tag, MSB=1 read, 0 write (master -> slave)
//   reqack   [1]      request beat accepted           (slave  -> master)
//   respcyc  [1]      response beat valid             (slave  -> master)
//   respack  [1]      response beat accepted          (master -> slave)
//   resp     [DATA_W] response data beat              (slave  -> master)
//   resptag  [TAG_W]  response tag                    (slave  -> master)
// Modports
//   master : the side that issues requests (a core master, or the arbiter
//            facing the shared bus)
//   slave  : the side that serves requests
// -----------------------------------------------------------------------------
interface sysbus_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13
);
    logic [DATA_W-1:0] req;
    logic              reqcyc;
    logic [TAG_W-1:0]  reqtag;
    logic              reqack;
    logic              respcyc;
    logic              respack;
    logic [DATA_W-1:0] resp;
    logic [TAG_W-1:0]  resptag;

    modport master (
        output req, reqcyc, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  req, reqcyc, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// -----------------------------------------------------------------------------
// sysbus_arbiter : two-master arbiter onto the core's single shared Sysbus.
//
// Master I is the instruction fetcher, master D is the data-memory
// refill/writeback unit. One master owns the bus for a whole transaction:
//   read  : one acked request beat, then BEATS response beats
//   write : one acked address beat plus BEATS acked data beats, no response
// All request/ack/response signals are routed between the owner and the bus;
// the non-owner (and everybody while IDLE) sees an idle bus.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   ibus       slave  modport of sysbus_if, master I
//   dbus       slave  modport of sysbus_if, master D
//   bus        master modport of sysbus_if, shared Sysbus
//   dbg_state  out  current FSM state (IDLE=0, I_REQ=1, I_RESP=2, D_REQ=3,
//                   D_RESP=4)
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined   : a tie goes to the master that did not own
//                                   the bus last (register resets to I, so D
//                                   wins the first tie).
//                       undefined : D always wins a tie (fixed priority).
// -----------------------------------------------------------------------------
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic       clk,
    input  logic       reset,
    sysbus_if.slave    ibus,
    sysbus_if.slave    dbus,
    sysbus_if.master   bus,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] I_REQ  = 3'd1;
    localparam logic [2:0] I_RESP = 3'd2;
    localparam logic [2:0] D_REQ  = 3'd3;
    localparam logic [2:0] D_RESP = 3'd4;

    // Last response beat index, and last write ack index (address + BEATS).
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
    localparam logic [3:0] LAST_WACK = 4'(BEATS);

    logic [2:0] state;
    logic [2:0] beat_cnt;
    logic [3:0] wr_cnt;

    logic                      sel_d;
    logic                      in_req;
    logic                      in_resp;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic                      own_reqcyc;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic                      own_respack;
    logic                      is_read;
    logic                      req_acked;
    logic                      beat_acc;
    logic                      grant_d;
    logic                      grant_i;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    logic last_owner;
`endif

    // Owner selection and the handshake events that move the FSM.
    always_comb begin
        sel_d       = (state == D_REQ) || (state == D_RESP);
        in_req      = (state == I_REQ) || (state == D_REQ);
        in_resp     = (state == I_RESP) || (state == D_RESP);
        own_req     = sel_d ? dbus.req     : ibus.req;
        own_reqcyc  = sel_d ? dbus.reqcyc  : ibus.reqcyc;
        own_reqtag  = sel_d ? dbus.reqtag  : ibus.reqtag;
        own_respack = sel_d ? dbus.respack : ibus.respack;
        is_read     = own_reqtag[BUS_TAG_WIDTH-1];
        req_acked   = in_req && own_reqcyc && bus.reqack;
        beat_acc    = in_resp && bus.respcyc && own_respack;
    end

    // Grant decision, only consumed in IDLE.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = dbus.reqcyc && (!ibus.reqcyc || (last_owner == OWN_I));
`else
        grant_d = dbus.reqcyc;
`endif
        grant_i = ibus.reqcyc && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= 3'd0;
            wr_cnt   <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= OWN_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= 3'd0;
                    wr_cnt   <= 4'd0;
                    if (grant_d) begin
                        state <= D_REQ;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= OWN_D;
`endif
                    end else if (grant_i) begin
                        state <= I_REQ;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= OWN_I;
`endif
                    end
                end
                I_REQ, D_REQ: begin
                    if (req_acked) begin
                        if (is_read) begin
                            // A read needs only its single request beat.
                            state <= sel_d ? D_RESP : I_RESP;
                        end else if (wr_cnt == LAST_WACK) begin
                            state  <= IDLE;
                            wr_cnt <= 4'd0;
                        end else begin
                            wr_cnt <= wr_cnt + 4'd1;
                        end
                    end
                end
                I_RESP, D_RESP: begin
                    if (beat_acc) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= IDLE;
                            beat_cnt <= 3'd0;
                        end else begin
                            beat_cnt <= beat_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= 3'd0;
                    wr_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Routing: the request channel is open only in a REQ state, the response
    // channel only in a RESP state. Everything else is held at zero, so a
    // stray bus_respcyc outside a RESP state is neither forwarded nor acked.
    always_comb begin
        bus.req      = '0;
        bus.reqcyc   = 1'b0;
        bus.reqtag   = '0;
        bus.respack  = 1'b0;
        ibus.reqack  = 1'b0;
        ibus.respcyc = 1'b0;
        ibus.resp    = '0;
        ibus.resptag = '0;
        dbus.reqack  = 1'b0;
        dbus.respcyc = 1'b0;
        dbus.resp    = '0;
        dbus.resptag = '0;
        if (in_req) begin
            bus.req    = own_req;
            bus.reqcyc = own_reqcyc;
            bus.reqtag = own_reqtag;
            if (sel_d) dbus.reqack = bus.reqack;
            else       ibus.reqack = bus.reqack;
        end
        if (in_resp) begin
            bus.respack = own_respack;
            if (sel_d) begin
                dbus.respcyc = bus.respcyc;
                dbus.resp    = bus.resp;
                dbus.resptag = bus.resptag;
            end else begin
                ibus.respcyc = bus.respcyc;
                ibus.resp    = bus.resp;
                ibus.resptag = bus.resptag;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sysbus_arbiter : directed bench for sysbus_arbiter.
// The bench plays both masters and the shared bus. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 more unit later.
// -----------------------------------------------------------------------------
module tb_sysbus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit TIE2_FIRST_D = 1'b0;
`else
    localparam bit TIE2_FIRST_D = 1'b1;
`endif

    sysbus_if #(.DATA_W(64), .TAG_W(13)) ibus ();
    sysbus_if #(.DATA_W(64), .TAG_W(13)) dbus ();
    sysbus_if #(.DATA_W(64), .TAG_W(13)) bus ();

    sysbus_arbiter #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .BEATS         (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ibus     (ibus),
        .dbus     (dbus),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input bit is_d, input logic cyc, input logic [63:0] a, input logic [12:0] t);
        if (is_d) begin
            dbus.reqcyc = cyc; dbus.req = a; dbus.reqtag = t;
        end else begin
            ibus.reqcyc = cyc; ibus.req = a; ibus.reqtag = t;
        end
    endtask

    // Owner gets v, the other master gets ~v so leakage would show up.
    task automatic set_respack(input bit is_d, input logic v);
        if (is_d) begin
            dbus.respack = v; ibus.respack = ~v;
        end else begin
            ibus.respack = v; dbus.respack = ~v;
        end
    endtask

    // Called one cycle after the grant edge (FSM in X_REQ). Runs a full read:
    // request ack, then 8 beats of base+k, optionally stalling 3 cycles
    // before beat stall_beat.
    task automatic run_read(input bit is_d, input logic [63:0] addr, input logic [12:0] t,
                            input logic [63:0] base, input int stall_beat);
        bus.reqack = 1'b1;
        #1;
        check("rd_bus_req",      bus.req, addr);
        check("rd_bus_reqcyc",   64'(bus.reqcyc), 64'd1);
        check("rd_bus_reqtag",   64'(bus.reqtag), 64'(t));
        check("rd_owner_reqack", 64'(is_d ? dbus.reqack : ibus.reqack), 64'd1);
        check("rd_other_reqack", 64'(is_d ? ibus.reqack : dbus.reqack), 64'd0);
        tick();
        drive_req(is_d, 1'b0, 64'd0, 13'd0);
        #1;
        check("rd_resp_bus_reqcyc", 64'(bus.reqcyc), 64'd0);
        check("rd_resp_bus_req",    bus.req, 64'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == stall_beat) begin
                for (int s = 0; s < 3; s++) begin
                    bus.respcyc = 1'b1; bus.resp = base + 64'(k); bus.resptag = t;
                    set_respack(is_d, 1'b0);
                    #1;
                    check("stall_bus_respack", 64'(bus.respack), 64'd0);
                    check("stall_owner_resp",  is_d ? dbus.resp : ibus.resp, base + 64'(k));
                    tick();
                end
            end
            bus.respcyc = 1'b1; bus.resp = base + 64'(k); bus.resptag = t;
            set_respack(is_d, 1'b1);
            #1;
            check("beat_owner_respcyc", 64'(is_d ? dbus.respcyc : ibus.respcyc), 64'd1);
            check("beat_owner_resp",    is_d ? dbus.resp : ibus.resp, base + 64'(k));
            check("beat_owner_resptag", 64'(is_d ? dbus.resptag : ibus.resptag), 64'(t));
            check("beat_bus_respack",   64'(bus.respack), 64'd1);
            check("beat_other_respcyc", 64'(is_d ? ibus.respcyc : dbus.respcyc), 64'd0);
            check("beat_other_reqack",  64'(is_d ? ibus.reqack : dbus.reqack), 64'd0);
            tick();
        end
        // Stray respcyc after the 8th beat must be ignored.
        #1;
        check("rd_end_idle",          64'(dbg_state), 64'd0);
        check("rd_end_bus_respack",   64'(bus.respack), 64'd0);
        check("rd_end_owner_respcyc", 64'(is_d ? dbus.respcyc : ibus.respcyc), 64'd0);
        bus.respcyc = 1'b0; bus.resp = 64'd0; bus.resptag = 13'd0;
        bus.reqack = 1'b0;
        ibus.respack = 1'b0; dbus.respack = 1'b0;
    endtask

    // Called one cycle after the grant edge. Address beat plus 8 data beats,
    // each acked; a stray bus_respcyc is held high throughout.
    task automatic run_write(input bit is_d, input logic [63:0] addr, input logic [12:0] t);
        for (int k = 0; k < 9; k++) begin
            logic [63:0] val;
            val = (k == 0) ? addr : (64'hD000 + 64'(k));
            drive_req(is_d, 1'b1, val, t);
            bus.reqack = 1'b1; bus.respcyc = 1'b1; bus.resp = 64'hBAD;
            #1;
            check("wr_bus_req",       bus.req, val);
            check("wr_bus_reqcyc",    64'(bus.reqcyc), 64'd1);
            check("wr_owner_reqack",  64'(is_d ? dbus.reqack : ibus.reqack), 64'd1);
            check("wr_ibus_respcyc",  64'(ibus.respcyc), 64'd0);
            check("wr_dbus_respcyc",  64'(dbus.respcyc), 64'd0);
            check("wr_bus_respack",   64'(bus.respack), 64'd0);
            tick();
        end
        drive_req(is_d, 1'b0, 64'd0, 13'd0);
        bus.reqack = 1'b0; bus.respcyc = 1'b0; bus.resp = 64'd0;
        #1;
        check("wr_end_idle",       64'(dbg_state), 64'd0);
        check("wr_end_bus_reqcyc", 64'(bus.reqcyc), 64'd0);
    endtask

    // Both masters request reads in the same cycle.
    task automatic run_tie(input bit first_d, input logic [63:0] base);
        drive_req(1'b0, 1'b1, 64'h4000, 13'h1004);
        drive_req(1'b1, 1'b1, 64'h5000, 13'h1005);
        tick();
        if (first_d) run_read(1'b1, 64'h5000, 13'h1005, base, -1);
        else         run_read(1'b0, 64'h4000, 13'h1004, base, -1);
        // Loser waits through the IDLE cycle.
        check("tie_wait_bus_reqcyc", 64'(bus.reqcyc), 64'd0);
        tick();
        if (first_d) run_read(1'b0, 64'h4000, 13'h1004, base + 64'h10, -1);
        else         run_read(1'b1, 64'h5000, 13'h1005, base + 64'h10, -1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        drive_req(1'b0, 1'b0, 64'd0, 13'd0);
        drive_req(1'b1, 1'b0, 64'd0, 13'd0);
        ibus.respack = 1'b0; dbus.respack = 1'b0;
        bus.reqack = 1'b0; bus.respcyc = 1'b1;
        bus.resp = 64'h55; bus.resptag = 13'h1fff;
        tick();
        tick();
        check("rst_state",        64'(dbg_state), 64'd0);
        check("rst_bus_reqcyc",   64'(bus.reqcyc), 64'd0);
        check("rst_ibus_respcyc", 64'(ibus.respcyc), 64'd0);
        check("rst_dbus_resp",    dbus.resp, 64'd0);
        check("rst_bus_respack",  64'(bus.respack), 64'd0);
        bus.respcyc = 1'b0; bus.resp = 64'd0; bus.resptag = 13'd0;
        reset = 1'b0;
        tick();

        // I read, 1-cycle arbitration latency.
        drive_req(1'b0, 1'b1, 64'h1000, 13'h1001);
        #1;
        check("lat_idle_bus_reqcyc", 64'(bus.reqcyc), 64'd0);
        tick();
        run_read(1'b0, 64'h1000, 13'h1001, 64'd0, -1);

        // I read with backpressure; D write raised mid-transaction waits.
        drive_req(1'b0, 1'b1, 64'h2000, 13'h1002);
        tick();
        drive_req(1'b1, 1'b1, 64'h3000, 13'h0003);
        run_read(1'b0, 64'h2000, 13'h1002, 64'h100, 4);
        check("wait_bus_reqcyc", 64'(bus.reqcyc), 64'd0);
        tick();
        run_write(1'b1, 64'h3000, 13'h0003);

        // Ties from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("tie_rst_state", 64'(dbg_state), 64'd0);
        run_tie(1'b1, 64'h200);
        drive_req(1'b1, 1'b1, 64'h6000, 13'h1006);
        tick();
        run_read(1'b1, 64'h6000, 13'h1006, 64'h300, -1);
        run_tie(TIE2_FIRST_D, 64'h400);

        // Reset during beat 4 of an I read.
        drive_req(1'b0, 1'b1, 64'h7000, 13'h1007);
        tick();
        bus.reqack = 1'b1;
        tick();
        drive_req(1'b0, 1'b0, 64'd0, 13'd0);
        bus.reqack = 1'b0;
        ibus.respack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.respcyc = 1'b1; bus.resp = 64'(k); bus.resptag = 13'h1007;
            tick();
        end
        bus.resp = 64'd4;
        #1;
        check("abort_beat4_resp", ibus.resp, 64'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_state",        64'(dbg_state), 64'd0);
        check("abort_ibus_respcyc", 64'(ibus.respcyc), 64'd0);
        check("abort_bus_respack",  64'(bus.respack), 64'd0);
        bus.respcyc = 1'b0; bus.resp = 64'd0; bus.resptag = 13'd0;
        ibus.respack = 1'b0;
        drive_req(1'b1, 1'b1, 64'h8000, 13'h1008);
        tick();
        run_read(1'b1, 64'h8000, 13'h1008, 64'h500, -1);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
